// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 reader.
//   dht11_state_e : reader FSM states
//   FRAME_BITS    : bits per sensor frame
//   *_LSB         : byte positions inside the 40-bit frame (MSB-first shift)
//   dht11_csum_ok : frame checksum test (sum of the four data bytes, no carry)
`timescale 1ns/1ps
package dht11_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        WAIT_ACK,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        DONE,
        ERROR
    } dht11_state_e;

    localparam int FRAME_BITS  = 40;
    localparam int HUM_INT_LSB = 32;
    localparam int HUM_DEC_LSB = 24;
    localparam int TMP_INT_LSB = 16;
    localparam int TMP_DEC_LSB = 8;
    localparam int CSUM_LSB    = 0;

    function automatic logic dht11_csum_ok(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[HUM_INT_LSB +: 8] + frame[HUM_DEC_LSB +: 8]
            + frame[TMP_INT_LSB +: 8] + frame[TMP_DEC_LSB +: 8];
        return sum == frame[CSUM_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht11_reader_if.sv
// dht11_reader_if: result bus from the DHT11 reader to the fan-speed controller.
//   humidity    : integral RH byte
//   temperature : integral degC byte
//   data_valid  : one-cycle pulse when humidity/temperature update
//   busy        : transaction in progress
//   error       : sticky timeout / checksum failure flag
// master = reader side (drives), slave = consumer side.
`timescale 1ns/1ps
interface dht11_reader_if;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       data_valid;
    logic       busy;
    logic       error;

    modport master (output humidity, temperature, data_valid, busy, error);
    modport slave  (input  humidity, temperature, data_valid, busy, error);
endinterface

// File: rtl/dht11_reader_us_tick_gen.sv
// us_tick_gen: one-cycle tick every CLK_FREQ_MHZ clocks (1 us time base).
//   clk, reset_p : clock, async active-high reset
//   restart      : reload the prescaler so the tick phase follows the caller
//   tick         : one-cycle pulse
// restart loads 1 rather than 0: the caller asserts it in the cycle it sees an
// edge, so that cycle is credited and an H us interval counts exactly H ticks.
// CLK_FREQ_MHZ must be at least 2.
`timescale 1ns/1ps
module us_tick_gen #(
    parameter int CLK_FREQ_MHZ = 125
) (
    input  logic clk,
    input  logic reset_p,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_MHZ - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)              div_cnt <= '0;
        else if (restart)         div_cnt <= CW'(1);
        else if (div_cnt == LAST) div_cnt <= '0;
        else                      div_cnt <= div_cnt + CW'(1);
    end

    assign tick = (div_cnt == LAST);
endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: free-running DHT11 single-wire reader.
//   clk, reset_p : clock, async active-high reset (releases the line at once)
//   dht11_data   : open-drain line, driven only 0 or Z, external pull-up
//   out_if       : humidity / temperature / data_valid / busy / error
// Build option: define DHT11_CHECKSUM_EN to reject frames whose checksum byte
// does not match; otherwise every complete 40-bit frame is accepted.
`timescale 1ns/1ps
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ   = 125,
    parameter int unsigned READ_PERIOD_MS = 2000,
    parameter int unsigned START_LOW_US   = 18000,
    parameter int unsigned BIT_THRESH_US  = 50,
    parameter int unsigned TIMEOUT_US     = 1000
) (
    input  logic            clk,
    input  logic            reset_p,
    inout  wire             dht11_data,
    dht11_reader_if.master  out_if
);
    localparam logic [31:0] PERIOD_US = 32'(READ_PERIOD_MS * 1000);
    localparam logic [31:0] START_US  = 32'(START_LOW_US);
    localparam logic [31:0] THRESH_US = 32'(BIT_THRESH_US);
    localparam logic [31:0] TOUT_US   = 32'(TIMEOUT_US);

    dht11_state_e          state, state_nxt;
    logic                  state_chg;
    logic                  tick;
    logic [31:0]           us_cnt;
    logic [2:0]            line_pipe;   // [1:0] synchronizer, [2] edge history
    logic                  line_rise, line_fall;
    logic [FRAME_BITS-1:0] shreg;
    logic [5:0]            bit_cnt;
    logic                  timeout;
    logic                  accept;
    logic                  drive_low;
    logic                  unused_bytes;

    us_tick_gen #(.CLK_FREQ_MHZ(CLK_FREQ_MHZ)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .restart (state_chg),
        .tick    (tick)
    );

    assign dht11_data = drive_low ? 1'b0 : 1'bz;

    // Idle line is high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) line_pipe <= 3'b111;
        else         line_pipe <= {line_pipe[1:0], dht11_data};
    end

    assign line_rise = line_pipe[1] & ~line_pipe[2];
    assign line_fall = ~line_pipe[1] & line_pipe[2];
    assign timeout   = (us_cnt >= TOUT_US);

`ifdef DHT11_CHECKSUM_EN
    assign accept = dht11_csum_ok(shreg);
`else
    assign accept = 1'b1;
`endif
    // Decimal bytes are never reported; the checksum byte is unused unless checked.
    assign unused_bytes = ^{shreg[HUM_DEC_LSB +: 8], shreg[TMP_DEC_LSB +: 8],
                            shreg[CSUM_LSB +: 8]};

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state <= IDLE;
        else         state <= state_nxt;
    end

    // WAIT_ACK waits for a falling edge, not a low level: right after release
    // the synchronizer still shows the host's own low for two cycles.
    always_comb begin
        state_nxt   = state;
        drive_low   = 1'b0;
        out_if.busy = 1'b0;
        unique case (state)
            IDLE:      if (us_cnt >= PERIOD_US) state_nxt = START;
            START: begin
                drive_low   = 1'b1;
                out_if.busy = 1'b1;
                if (us_cnt >= START_US) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                out_if.busy = 1'b1;
                if (line_fall)    state_nxt = RESP_LOW;
                else if (timeout) state_nxt = ERROR;
            end
            RESP_LOW: begin
                out_if.busy = 1'b1;
                if (line_rise)    state_nxt = RESP_HIGH;
                else if (timeout) state_nxt = ERROR;
            end
            RESP_HIGH: begin
                out_if.busy = 1'b1;
                if (line_fall)    state_nxt = BIT_LOW;
                else if (timeout) state_nxt = ERROR;
            end
            BIT_LOW: begin
                out_if.busy = 1'b1;
                if (line_rise)    state_nxt = BIT_HIGH;
                else if (timeout) state_nxt = ERROR;
            end
            BIT_HIGH: begin
                out_if.busy = 1'b1;
                if (line_fall)
                    state_nxt = (bit_cnt == 6'(FRAME_BITS - 1)) ? DONE : BIT_LOW;
                else if (timeout)
                    state_nxt = ERROR;
            end
            DONE:    state_nxt = accept ? IDLE : ERROR;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign state_chg = (state_nxt != state);

    // A state change (line edge) has priority over a coincident tick.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)        us_cnt <= '0;
        else if (state_chg) us_cnt <= '0;
        else if (tick)      us_cnt <= us_cnt + 32'd1;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            shreg              <= '0;
            bit_cnt            <= '0;
            out_if.humidity    <= '0;
            out_if.temperature <= '0;
            out_if.data_valid  <= 1'b0;
            out_if.error       <= 1'b0;
        end else begin
            out_if.data_valid <= 1'b0;
            unique case (state)
                BIT_HIGH: if (line_fall) begin
                    shreg   <= {shreg[FRAME_BITS-2:0], (us_cnt > THRESH_US)};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                DONE: begin
                    if (accept) begin
                        out_if.humidity    <= shreg[HUM_INT_LSB +: 8];
                        out_if.temperature <= shreg[TMP_INT_LSB +: 8];
                        out_if.data_valid  <= 1'b1;
                        out_if.error       <= 1'b0;
                    end
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
                ERROR: begin
                    out_if.error <= 1'b1;
                    shreg        <= '0;
                    bit_cnt      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_reader.sv
`timescale 1ns/1ps
module tb_dht11_reader;
    localparam int CF       = 2;     // clocks per us in simulation
    localparam int PER_MS   = 1;
    localparam int START_US = 20;
    localparam int TO_US    = 200;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    logic bfm_low = 1'b0;
    wire  dline;

    pullup (dline);
    assign dline = bfm_low ? 1'b0 : 1'bz;

    dht11_reader_if rif ();

    dht11_reader #(
        .CLK_FREQ_MHZ   (CF),
        .READ_PERIOD_MS (PER_MS),
        .START_LOW_US   (START_US),
        .BIT_THRESH_US  (50),
        .TIMEOUT_US     (TO_US)
    ) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .dht11_data (dline),
        .out_if     (rif)
    );

    always #250 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int dv_cnt = 0;

    always @(negedge clk) if (rif.data_valid === 1'b1) dv_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_us(input int n);
        repeat (n * CF) @(negedge clk);
    endtask

    // Counts negedges until the host pulls low, then the length of that low.
    task automatic wait_start(output int idle, output int low);
        idle = 0;
        low  = 0;
        while (dline !== 1'b0 && idle < 3000 * CF) begin @(negedge clk); idle++; end
        while (dline === 1'b0 && low < 100 * CF)   begin @(negedge clk); low++;  end
    endtask

    // Sensor response after host release: ack low/high, then nbits MSB-first.
    task automatic sensor_frame(input logic [39:0] f, input int hi0, input int hi1,
                                input int nbits);
        wait_us(20);
        bfm_low = 1'b1; wait_us(80);
        bfm_low = 1'b0; wait_us(80);
        for (int i = 39; i >= 40 - nbits; i--) begin
            bfm_low = 1'b1; wait_us(30);
            bfm_low = 1'b0; wait_us(f[i] ? hi1 : hi0);
        end
        if (nbits == 40) begin
            bfm_low = 1'b1; wait_us(30);
            bfm_low = 1'b0;
        end
    endtask

    initial begin
        #(200_000 * 500);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idle, low, dv0;

        repeat (10) @(negedge clk);
        chk("rst_line",  32'(dline), 1);
        chk("rst_busy",  32'(rif.busy), 0);
        chk("rst_hum",   32'(rif.humidity), 0);
        chk("rst_temp",  32'(rif.temperature), 0);
        chk("rst_dv",    32'(rif.data_valid), 0);
        chk("rst_err",   32'(rif.error), 0);
        reset_p = 1'b0;

        // Frame 1: nominal 26/70 us highs.
        wait_start(idle, low);
        chk("idle1_len", 32'(idle >= 1000 * CF - 4 && idle <= 1000 * CF + 4), 1);
        chk("start1_low", 32'(low), START_US * CF);
        chk("busy1", 32'(rif.busy), 1);
        dv0 = dv_cnt;
        sensor_frame(40'h3C_00_19_00_55, 26, 70, 40);
        wait_us(2);
        chk("f1_hum",  32'(rif.humidity), 60);
        chk("f1_temp", 32'(rif.temperature), 25);
        chk("f1_dv",   32'(dv_cnt - dv0), 1);
        chk("f1_err",  32'(rif.error), 0);
        chk("f1_busy", 32'(rif.busy), 0);

        // Frame 2: threshold boundary, 50 us -> 0 and 51 us -> 1.
        wait_start(idle, low);
        chk("start2_low", 32'(low), START_US * CF);
        dv0 = dv_cnt;
        sensor_frame(40'h5A_00_21_00_7B, 50, 51, 40);
        wait_us(2);
        chk("f2_hum",  32'(rif.humidity), 32'h5A);
        chk("f2_temp", 32'(rif.temperature), 32'h21);
        chk("f2_dv",   32'(dv_cnt - dv0), 1);

        // Frame 3: sensor silent -> timeout.
        wait_start(idle, low);
        chk("start3_low", 32'(low), START_US * CF);
        dv0 = dv_cnt;
        wait_us(190);
        chk("to_early_err",  32'(rif.error), 0);
        chk("to_early_busy", 32'(rif.busy), 1);
        wait_us(20);
        chk("to_err",  32'(rif.error), 1);
        chk("to_busy", 32'(rif.busy), 0);
        chk("to_hum",  32'(rif.humidity), 32'h5A);
        chk("to_temp", 32'(rif.temperature), 32'h21);
        chk("to_dv",   32'(dv_cnt - dv0), 0);

        // Frame 4: good frame with nonzero decimal bytes clears error.
        wait_start(idle, low);
        dv0 = dv_cnt;
        sensor_frame(40'h37_05_16_03_55, 26, 70, 40);
        wait_us(2);
        chk("f4_hum",  32'(rif.humidity), 32'h37);
        chk("f4_temp", 32'(rif.temperature), 32'h16);
        chk("f4_err",  32'(rif.error), 0);
        chk("f4_dv",   32'(dv_cnt - dv0), 1);

        // Frame 5: bad checksum.
        wait_start(idle, low);
        dv0 = dv_cnt;
        sensor_frame(40'h3C_00_19_00_56, 26, 70, 40);
        wait_us(2);
`ifdef DHT11_CHECKSUM_EN
        chk("csum_err",  32'(rif.error), 1);
        chk("csum_hum",  32'(rif.humidity), 32'h37);
        chk("csum_temp", 32'(rif.temperature), 32'h16);
        chk("csum_dv",   32'(dv_cnt - dv0), 0);
`else
        chk("csum_err",  32'(rif.error), 0);
        chk("csum_hum",  32'(rif.humidity), 60);
        chk("csum_temp", 32'(rif.temperature), 25);
        chk("csum_dv",   32'(dv_cnt - dv0), 1);
`endif

        // Frame 6: reset after bit 20, then a full frame after the new period.
        wait_start(idle, low);
        sensor_frame(40'h3C_00_19_00_55, 26, 70, 20);
        reset_p = 1'b1;
        #1;
        chk("mid_rst_line", 32'(dline), 1);
        chk("mid_rst_hum",  32'(rif.humidity), 0);
        chk("mid_rst_temp", 32'(rif.temperature), 0);
        chk("mid_rst_busy", 32'(rif.busy), 0);
        chk("mid_rst_err",  32'(rif.error), 0);
        repeat (4) @(negedge clk);
        reset_p = 1'b0;
        wait_start(idle, low);
        chk("idle6_len", 32'(idle >= 1000 * CF - 4 && idle <= 1000 * CF + 4), 1);
        chk("start6_low", 32'(low), START_US * CF);
        dv0 = dv_cnt;
        sensor_frame(40'h3C_00_19_00_55, 26, 70, 40);
        wait_us(2);
        chk("f6_hum",  32'(rif.humidity), 60);
        chk("f6_temp", 32'(rif.temperature), 25);
        chk("f6_dv",   32'(dv_cnt - dv0), 1);
        chk("f6_err",  32'(rif.error), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
